// File: rtl/mem_preload_ctrl.sv
// rtl/mem_preload_ctrl.sv - streamed memory preload/verify controller; read-back verify enabled by MEM_PRELOAD_VERIFY_EN
module mem_preload_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  hold_cpu,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef MEM_PRELOAD_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  handshake;
  logic                  last_word;
  logic                  drain_empty;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // s_ready depends only on state and remaining count so the source never sees a loop through s_valid
  assign s_ready   = ((state_q == ST_LOAD) || (state_q == ST_VERIFY)) && (idx_q != len_q);
  assign handshake = s_valid && s_ready;
  assign idx_inc   = idx_q + 1'b1;
  assign last_word = (idx_inc == len_q);
  // MEM_DEPTH is a power of two, so the truncating add gives the wrap-around address
  assign cur_addr  = base_q + idx_q[ADDR_WIDTH-1:0];

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY) || (state_q == ST_DRAIN);
  assign hold_cpu  = busy;
  assign done      = (state_q == ST_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Sequencer: latch the request, walk the region, issue one registered access per handshake
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          base_d = base_addr;
          len_d  = length;
          idx_d  = '0;
          if (length == '0) begin
            state_d = ST_DONE;
          end else if (mode == 2'd1) begin
            state_d = VERIFY_EN ? ST_VERIFY : ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr;
          mem_wdata_d = s_data;
          idx_d       = idx_inc;
          if (last_word) begin
            if (VERIFY_EN && (mode_q == 2'd2)) begin
              state_d = ST_VERIFY;
              idx_d   = '0;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_VERIFY: begin
        if (handshake) begin
          mem_addr_d = cur_addr;
          idx_d      = idx_inc;
          if (last_word) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and write-port registers; reset stops any access immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_PRELOAD_VERIFY_EN
  logic                  mem_re_q, mem_re_d;
  logic [DATA_WIDTH-1:0] exp1_q, exp1_d;
  logic [DATA_WIDTH-1:0] exp2_q, exp2_d;
  logic                  cmp_q, cmp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;

  // A read still in flight means its compare lands next cycle
  assign drain_empty    = !mem_re_q;
  assign mem_re         = mem_re_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  // Expected word trails the read by two stages so it meets mem_rdata; mismatches counted saturating
  always_comb begin
    mem_re_d   = (state_q == ST_VERIFY) && handshake;
    exp1_d     = mem_re_d ? s_data : exp1_q;
    exp2_d     = exp1_q;
    cmp_d      = mem_re_q;
    cmp_addr_d = mem_addr_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d  = '0;
      ferr_d = '0;
    end else if (cmp_q && (mem_rdata != exp2_q)) begin
      if (err_q == '0) begin
        ferr_d = cmp_addr_q;
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  // Read/compare pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_re_q   <= 1'b0;
      exp1_q     <= '0;
      exp2_q     <= '0;
      cmp_q      <= 1'b0;
      cmp_addr_q <= '0;
      err_q      <= '0;
      ferr_q     <= '0;
    end else begin
      mem_re_q   <= mem_re_d;
      exp1_q     <= exp1_d;
      exp2_q     <= exp2_d;
      cmp_q      <= cmp_d;
      cmp_addr_q <= cmp_addr_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
    end
  end
`else
  logic unused_rdata;

  assign drain_empty    = 1'b1;
  assign unused_rdata   = ^mem_rdata;
  assign mem_re         = 1'b0;
  assign err_count      = '0;
  assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// tb/tb_mem_preload_ctrl.sv - directed self-checking bench for mem_preload_ctrl
module tb_mem_preload_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic        mem_re;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        hold_cpu;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [10:0] first_err_addr;

  mem_preload_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hold_cpu(hold_cpu), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];
  logic [10:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  logic [7:0]  src [0:63];
  int cyc = 0;
  int busy_total = 0;
  int done_total = 0;
  int last_done_cyc = 0;
  int hold_bad = 0;
  int s0, busy0, done0, wr0, consumed;
  int n_checks = 0;
  int n_fail = 0;

  // Memory model with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Access log and status counters, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (busy) busy_total++;
    if (done) begin
      done_total++;
      last_done_cyc = cyc;
    end
    if (hold_cpu !== busy) hold_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [10:0] b, input logic [11:0] n,
                        input int nwords, input bit gaps, input int restart_at);
    int k = 0;
    int guard = 0;
    bit hs;
    @(negedge clk);
    mode = m; base_addr = b; length = n; start = 1'b1;
    s0 = cyc; busy0 = busy_total; done0 = done_total; wr0 = wr_addr.size();
    @(negedge clk);
    start = 1'b0;
    while (done_total == done0 && guard < 300) begin
      start   = (guard == restart_at);
      s_valid = (k < nwords) && (!gaps || (guard % 2 == 0));
      s_data  = src[k];
      hs      = s_valid && s_ready;
      @(negedge clk);
      if (hs) k++;
      guard++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    check("op_done_seen", done_total - done0, 1);
    consumed = k;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [10:0] b, input int off);
    logic [10:0] ea;
    check({tag, "_wcount"}, wr_addr.size() - wr0, n);
    for (int i = 0; i < n && (wr0 + i) < wr_addr.size(); i++) begin
      ea = b + 11'(i);
      check({tag, "_waddr"}, wr_addr[wr0 + i], ea);
      check({tag, "_wdata"}, wr_data[wr0 + i], src[i + off]);
    end
  endtask

  initial begin
    int k;
    int guard;
    reset = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0; length = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sready", s_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_done", done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_err", err_count, 0);
    check("rst_ferr", first_err_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Load: 8 words from 0x000
    for (int i = 0; i < 8; i++) src[i] = 8'h10 + 8'(i);
    run_op(2'd0, 11'h000, 12'd8, 8, 1'b0, -1);
    check_writes("load", 8, 11'h000, 0);
    check("load_done_lat", last_done_cyc - s0, 10);
    check("load_busy_cycles", busy_total - busy0, 9);

    // Verify-only of the region just loaded
    run_op(2'd1, 11'h000, 12'd8, 8, 1'b0, -1);
    check("v1_writes", wr_addr.size() - wr0, 0);
`ifdef MEM_PRELOAD_VERIFY_EN
    check("v1_done_lat", last_done_cyc - s0, 11);
    check("v1_busy_cycles", busy_total - busy0, 10);
    check("v1_consumed", consumed, 8);
    check("v1_err", err_count, 0);
`else
    check("v1_done_lat", last_done_cyc - s0, 1);
    check("v1_busy_cycles", busy_total - busy0, 0);
    check("v1_consumed", consumed, 0);
`endif

    // Wrap past top of memory, reserved mode 3 behaves as load
    for (int i = 0; i < 4; i++) src[i] = 8'hA0 + 8'(i);
    run_op(2'd3, 11'h7FE, 12'd4, 4, 1'b0, -1);
    check_writes("wrap", 4, 11'h7FE, 0);
    if (wr_addr.size() >= wr0 + 4) check("wrap_addr2", wr_addr[wr0 + 2], 11'h000);

    // Backpressure: s_valid alternates
    for (int i = 0; i < 6; i++) src[i] = 8'h30 + 8'(i);
    run_op(2'd0, 11'h020, 12'd6, 6, 1'b1, -1);
    check_writes("bp", 6, 11'h020, 0);
    check("bp_consumed", consumed, 6);

    // Start re-asserted during load is ignored
    for (int i = 0; i < 8; i++) src[i] = 8'h50 + 8'(i);
    run_op(2'd0, 11'h040, 12'd8, 8, 1'b0, 3);
    check_writes("restart", 8, 11'h040, 0);
    check("restart_done_lat", last_done_cyc - s0, 10);
    check("restart_busy_cycles", busy_total - busy0, 9);

    // Length 0
    run_op(2'd0, 11'h100, 12'd0, 0, 1'b0, -1);
    check("len0_done_lat", last_done_cyc - s0, 1);
    check("len0_writes", wr_addr.size() - wr0, 0);
    check("len0_busy_cycles", busy_total - busy0, 0);

    // Load then verify with offsets 5 and 9 corrupted in the second pass
    for (int i = 0; i < 16; i++) begin
      src[i] = 8'h60 + 8'(i);
      src[i + 16] = 8'h60 + 8'(i);
    end
    src[21] = src[21] ^ 8'hFF;
    src[25] = src[25] ^ 8'hFF;
    run_op(2'd2, 11'h000, 12'd16, 32, 1'b0, -1);
    check_writes("lv", 16, 11'h000, 0);
`ifdef MEM_PRELOAD_VERIFY_EN
    check("lv_consumed", consumed, 32);
    check("lv_err", err_count, 2);
    check("lv_first_err", first_err_addr, 11'h005);
`else
    check("lv_consumed", consumed, 16);
    check("lv_err", err_count, 0);
    check("lv_first_err", first_err_addr, 0);
`endif

    // Next start clears the error record
    src[0] = 8'hEE;
    run_op(2'd0, 11'h200, 12'd1, 1, 1'b0, -1);
    check("clr_err", err_count, 0);
    check("clr_first_err", first_err_addr, 0);

    // Reset in the middle of a load
    for (int i = 0; i < 8; i++) src[i] = 8'h70 + 8'(i);
    @(negedge clk);
    mode = 2'd0; base_addr = 11'h300; length = 12'd8; start = 1'b1;
    wr0 = wr_addr.size();
    @(negedge clk);
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 3 && guard < 50) begin
      s_valid = 1'b1;
      s_data  = src[k];
      if (s_ready) k++;
      @(negedge clk);
      guard++;
    end
    #2;
    reset = 1'b1;
    s_valid = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hold", hold_cpu, 0);
    check("mid_rst_sready", s_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_writes("mid_rst", 3, 11'h300, 0);
    run_op(2'd0, 11'h300, 12'd8, 8, 1'b0, -1);
    check_writes("after_rst", 8, 11'h300, 0);
    check("after_rst_done_lat", last_done_cyc - s0, 10);

    check("hold_eq_busy", hold_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_preload_ctrl.md
# mem_preload_ctrl

Synthesizable memory preload/verify controller, the parametrised successor to the bench-only memory override. While `hold_cpu` stalls the core, it streams an image from a valid/ready source into any on-chip memory (CPU RAM, PPU VRAM, OAM) through a registered write port. With the feature enabled, it also reads the region back and counts mismatches against a second pass of the same stream. One instance sits in front of each memory's write port mux.

## Interface
- `DATA_WIDTH`, default 8: memory word width.
- `MEM_DEPTH`, default 2048: words in target memory; must be a power of 2.
- `ADDR_WIDTH`, default $clog2(MEM_DEPTH): address width.
- `ERR_WIDTH`, default 16: mismatch counter width.
- `clk`  in  1: clock.
- `reset`  in  1: reset; asynchronous, active-high.
- `start`  in  1: begin an operation; ignored unless IDLE.
- `mode`  in  2: 0 = load, 1 = verify only, 2 = load then verify, 3 = reserved (treated as 0).
- `base_addr`  in  ADDR_WIDTH: first word address.
- `length`  in  ADDR_WIDTH+1: word count, 0..MEM_DEPTH.
- `s_valid`  in  1: source word valid.
- `s_data`  in  DATA_WIDTH: source word.
- `s_ready`  out  1: source word accepted when `s_valid & s_ready`.
- `mem_we`  out  1: write strobe.
- `mem_re`  out  1: read strobe; memory returns data one cycle later.
- `mem_addr`  out  ADDR_WIDTH: access address.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `mem_rdata`  in  DATA_WIDTH: read data, valid the cycle after `mem_re`.
- `hold_cpu`  out  1: stall request; equal to busy.
- `busy`  out  1: operation in progress.
- `done`  out  1: single-cycle completion pulse.
- `err_count`  out  ERR_WIDTH: mismatches since last start; saturating.
- `first_err_addr`  out  ADDR_WIDTH: address of first mismatch.

## Operation
- States: IDLE, LOAD, VERIFY, DRAIN, DONE.
- IDLE → LOAD when `start` and mode ∈ {0,2,3}.
- IDLE → VERIFY when `start` and mode = 1.
- On start, the controller latches `base_addr`, `length` and `mode`, and clears `err_count` and `first_err_addr`.
- `length` = 0: go straight to DONE with no memory access.
- Address sequence: `base_addr + i` mod MEM_DEPTH. A region may wrap past the top of memory.
- LOAD:
  - `s_ready` = 1 while words remain.
  - Each handshake issues one write.
  - After the last handshake: mode 2 → VERIFY (word index reset to 0); otherwise → DRAIN.
- VERIFY:
  - `s_ready` = 1 while words remain.
  - Each handshake issues one read and holds the expected word in a 2-stage pipeline.
  - When `mem_rdata` ≠ expected, `err_count` increments, saturating at all-ones.
  - `first_err_addr` records the address of the first mismatch only.
  - After the last handshake → DRAIN.
- DRAIN: wait until the write/read pipeline is empty (at most 2 cycles), then → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE.
- `s_valid` low stalls the controller with no side effects; gaps are allowed anywhere.
- `start` while busy is ignored.
- `err_count` and `first_err_addr` hold their values until the next start.

## Timing
- Reset values: `s_ready`, `mem_we`, `mem_re`, `busy`, `hold_cpu`, `done` = 0. `mem_addr`, `mem_wdata`, `err_count`, `first_err_addr` = 0. State = IDLE.
- `reset` clears all outputs asynchronously, including in the middle of an operation. No further access is issued.
- `start` sampled at edge T: `busy` = 1 and `s_ready` = 1 from T+1.
- `mem_we`, `mem_re`, `mem_addr` and `mem_wdata` are registered. They are driven in the cycle after the handshake.
- Throughput: one word per cycle.
- Verify latency:
  - Handshake at cycle N.
  - `mem_re` at N+1.
  - `mem_rdata` compared at the end of N+2.
  - `err_count` updated from N+3.
- `done` is asserted the cycle after the last write (load) or the last compare (verify). `busy` falls in the same cycle `done` rises.
- `s_ready` is combinational from state and remaining count only, never from `s_valid`.

## Configuration
- `MEM_PRELOAD_VERIFY_EN` defined: VERIFY state, read path, `err_count` and `first_err_addr` are implemented as above.
- Not defined:
  - Mode 2 behaves as mode 0.
  - Mode 1 goes from start directly to DONE, consuming no stream words.
  - `mem_re`, `err_count` and `first_err_addr` are tied to 0.
  - `mem_rdata` is unused.

## Test plan
- Load:
  - Stimulus: mode 0, base 0x000, length 8, data 0x10..0x17 with continuous `s_valid`.
  - Required: 8 consecutive `mem_we` to addresses 0x000..0x007 with matching data; `done` 10 cycles after start; `busy` high for 9 cycles.
- Wrap:
  - Stimulus: mode 0, base 0x7FE, length 4, MEM_DEPTH 2048.
  - Required: writes to 0x7FE, 0x7FF, 0x000, 0x001.
- Verify:
  - Stimulus: mode 2, length 16. In the verify pass, the word at offset 5 (0x005) and the word at offset 9 are corrupted.
  - Required: `err_count` = 2; `first_err_addr` = 0x005.
- Backpressure:
  - Stimulus: `s_valid` toggled 1-0-1-0 during load.
  - Required: writes occur only after handshakes, with no duplicates or drops.
- Reset mid-LOAD:
  - Stimulus: `reset` asserted at word 3.
  - Required: all outputs 0 immediately, state IDLE; a new start then works normally.
- Length 0 and start while busy:
  - Length 0: `done` at T+1, with no `mem_we`.
  - `start` re-asserted during LOAD: ignored, counts unchanged.
